// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - scoreboard hazard, redirect-flush and freeze control for fetch/decode
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             issue,
    output logic             if_stall,
    output logic             id_stall,
    output logic             id_flush,
    output logic             ex_bubble,
    output logic [31:0]      busy_mask,
    output logic [4:0]       inflight,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [4:0] MAX_W      = 5'(MAX_INFLIGHT);

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt, flush_cnt_nxt;
    logic [31:0] mask_nxt;
    logic [4:0]  inflight_nxt, inflight_eff;
    logic        wb_hit, set_en, cap, hazard;
    logic        pend_rs1, pend_rs2, pend_rd;

    // A writeback in the same cycle resolves the dependency: the regfile writes through.
    assign pend_rs1 = busy_mask[id_rs1] && !(wb_valid && wb_rd == id_rs1) && id_rs1 != 5'd0;
    assign pend_rs2 = busy_mask[id_rs2] && !(wb_valid && wb_rd == id_rs2) && id_rs2 != 5'd0;
    assign pend_rd  = busy_mask[id_rd]  && !(wb_valid && wb_rd == id_rd)  && id_rd  != 5'd0;

    assign wb_hit       = wb_valid && wb_rd != 5'd0 && busy_mask[wb_rd];
    assign inflight_eff = inflight - {4'd0, wb_hit};
    assign cap          = id_reg_write && id_rd != 5'd0 && inflight_eff == MAX_W;
    assign hazard       = id_valid && ((id_uses_rs1 && pend_rs1) || (id_uses_rs2 && pend_rs2) ||
                                       (id_reg_write && pend_rd) || cap);

    assign id_flush  = ex_redirect || state == FLUSH;
    assign issue     = id_valid && state == RUN && !ex_redirect && !mem_busy && !hazard;
    assign id_stall  = !id_flush && (mem_busy || (id_valid && hazard));
    assign if_stall  = id_stall;
    assign ex_bubble = !mem_busy && (id_flush || (id_valid && hazard));
    assign set_en    = issue && id_reg_write && id_rd != 5'd0;

    // Flush counter holds the FLUSH cycles still owed after the redirect cycle itself.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            RUN: begin
                if (ex_redirect && FLUSH_CYCLES > 1) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (ex_redirect) begin
                    flush_cnt_nxt = FLUSH_LOAD;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1) begin
                        state_nxt     = RUN;
                        flush_cnt_nxt = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt     = RUN;
                flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Set is applied after clear so a same-register set/clear leaves the bit pending.
    always_comb begin
        mask_nxt = busy_mask;
        if (wb_valid) mask_nxt[wb_rd] = 1'b0;
        if (set_en) mask_nxt[id_rd] = 1'b1;
        mask_nxt[0] = 1'b0;
        inflight_nxt = inflight;
        if (set_en && !wb_hit && inflight < MAX_W) inflight_nxt = inflight + 5'd1;
        else if (!set_en && wb_hit) inflight_nxt = inflight - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= RUN;
            flush_cnt    <= 4'd0;
            busy_mask    <= 32'd0;
            inflight     <= 5'd0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            busy_mask <= mask_nxt;
            inflight  <= inflight_nxt;
            if (id_stall && stall_cycles != {CNT_W{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard-driven bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        ex_redirect, mem_busy, wb_valid;
    logic        issue, if_stall, id_stall, id_flush, ex_bubble;
    logic [31:0] busy_mask;
    logic [4:0]  inflight;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;

    // outs = {issue, id_stall, if_stall, id_flush, ex_bubble}; mask/infl are post-edge values
    typedef struct packed {
        logic        v, u1; logic [4:0] rs1;
        logic        u2;    logic [4:0] rs2;
        logic        rw;    logic [4:0] rd;
        logic        redir, mb, wbv; logic [4:0] wbrd;
        logic [4:0]  outs;
        logic [31:0] mask;
        logic [4:0]  infl;
    } step_t;

    step_t tbl[$];
    step_t exp_q[$];

    hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_INFLIGHT(4), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .issue(issue), .if_stall(if_stall),
        .id_stall(id_stall), .id_flush(id_flush), .ex_bubble(ex_bubble),
        .busy_mask(busy_mask), .inflight(inflight), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(logic v, logic u1, logic [4:0] rs1, logic u2, logic [4:0] rs2,
                                 logic rw, logic [4:0] rd, logic redir, logic mb, logic wbv,
                                 logic [4:0] wbrd, logic [4:0] outs, logic [31:0] mask,
                                 logic [4:0] infl);
        step_t s;
        s.v = v; s.u1 = u1; s.rs1 = rs1; s.u2 = u2; s.rs2 = rs2; s.rw = rw; s.rd = rd;
        s.redir = redir; s.mb = mb; s.wbv = wbv; s.wbrd = wbrd;
        s.outs = outs; s.mask = mask; s.infl = infl;
        return s;
    endfunction

    task automatic drive(step_t s);
        id_valid = s.v; id_uses_rs1 = s.u1; id_rs1 = s.rs1; id_uses_rs2 = s.u2; id_rs2 = s.rs2;
        id_reg_write = s.rw; id_rd = s.rd; ex_redirect = s.redir; mem_busy = s.mb;
        wb_valid = s.wbv; wb_rd = s.wbrd;
        exp_q.push_back(s);
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,5'b0,32'd0,5'd0));
        void'(exp_q.pop_back());
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
            id_reg_write = 1'($urandom); ex_redirect = 1'($urandom); mem_busy = 1'($urandom);
            wb_valid = 1'($urandom); wb_rd = 5'($urandom);
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        idle();
        #1;
        checks++; if (busy_mask !== 32'd0) begin failures++; $display("FAIL reset busy_mask got=%h want=0", busy_mask); end
        checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL reset inflight got=%0d want=0", inflight); end
        checks++; if (issue !== 1'b0) begin failures++; $display("FAIL reset issue got=%b want=0", issue); end
        checks++; if (id_flush !== 1'b0) begin failures++; $display("FAIL reset id_flush got=%b want=0", id_flush); end
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset stall_cycles got=%0d want=0", stall_cycles); end
        exp_stall = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_raw();
        step_t e;
        tbl.delete();
        tbl.push_back(mk(1,0,0,0,0,1,5,0,0,0,0, 5'b10000, 32'h20, 5'd1));
        tbl.push_back(mk(1,0,0,1,5,0,0,0,0,0,0, 5'b01101, 32'h20, 5'd1));
        tbl.push_back(mk(1,0,0,0,0,1,5,0,0,0,0, 5'b01101, 32'h20, 5'd1));
        tbl.push_back(mk(1,1,5,0,0,0,0,0,0,0,0, 5'b01101, 32'h20, 5'd1));
        tbl.push_back(mk(1,1,5,0,0,0,0,0,0,1,5, 5'b10000, 32'h00, 5'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]); #1;
            e = exp_q.pop_front();
            checks++;
            if ({issue, id_stall, if_stall, id_flush, ex_bubble} !== e.outs) begin
                failures++; $display("FAIL raw[%0d] outs got=%b want=%b", i, {issue, id_stall, if_stall, id_flush, ex_bubble}, e.outs);
            end
            if (e.outs[3]) exp_stall++;
            @(posedge clk); #1;
            checks++;
            if (busy_mask !== e.mask || inflight !== e.infl) begin
                failures++; $display("FAIL raw[%0d] state got=%h/%0d want=%h/%0d", i, busy_mask, inflight, e.mask, e.infl);
            end
        end
    endtask

    task automatic test_redirect();
        step_t e;
        tbl.delete();
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 5'b00011, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 5'b00011, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 5'b10000, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 5'b00011, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 5'b00011, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 5'b00011, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 5'b10000, 32'h0, 5'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]); #1;
            e = exp_q.pop_front();
            checks++;
            if ({issue, id_stall, if_stall, id_flush, ex_bubble} !== e.outs) begin
                failures++; $display("FAIL redirect[%0d] outs got=%b want=%b", i, {issue, id_stall, if_stall, id_flush, ex_bubble}, e.outs);
            end
            if (e.outs[3]) exp_stall++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_capacity();
        step_t e;
        tbl.delete();
        tbl.push_back(mk(1,0,0,0,0,1,1,0,0,0,0, 5'b10000, 32'h02, 5'd1));
        tbl.push_back(mk(1,0,0,0,0,1,2,0,0,0,0, 5'b10000, 32'h06, 5'd2));
        tbl.push_back(mk(1,0,0,0,0,1,3,0,0,0,0, 5'b10000, 32'h0E, 5'd3));
        tbl.push_back(mk(1,0,0,0,0,1,4,0,0,0,0, 5'b10000, 32'h1E, 5'd4));
        tbl.push_back(mk(1,0,0,0,0,1,6,0,0,0,0, 5'b01101, 32'h1E, 5'd4));
        tbl.push_back(mk(1,0,0,0,0,1,6,0,0,1,1, 5'b10000, 32'h5C, 5'd4));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,2, 5'b00000, 32'h58, 5'd3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,3, 5'b00000, 32'h50, 5'd2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,4, 5'b00000, 32'h40, 5'd1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,6, 5'b00000, 32'h00, 5'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]); #1;
            e = exp_q.pop_front();
            checks++;
            if ({issue, id_stall, if_stall, id_flush, ex_bubble} !== e.outs) begin
                failures++; $display("FAIL capacity[%0d] outs got=%b want=%b", i, {issue, id_stall, if_stall, id_flush, ex_bubble}, e.outs);
            end
            if (e.outs[3]) exp_stall++;
            @(posedge clk); #1;
            checks++;
            if (busy_mask !== e.mask || inflight !== e.infl) begin
                failures++; $display("FAIL capacity[%0d] state got=%h/%0d want=%h/%0d", i, busy_mask, inflight, e.mask, e.infl);
            end
        end
    endtask

    task automatic test_freeze();
        step_t e;
        tbl.delete();
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0,0, 5'b01100, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,1,0,0, 5'b00010, 32'h0, 5'd0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 5'b00011, 32'h0, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 5'b10000, 32'h0, 5'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]); #1;
            e = exp_q.pop_front();
            checks++;
            if ({issue, id_stall, if_stall, id_flush, ex_bubble} !== e.outs) begin
                failures++; $display("FAIL freeze[%0d] outs got=%b want=%b", i, {issue, id_stall, if_stall, id_flush, ex_bubble}, e.outs);
            end
            if (e.outs[3]) exp_stall++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles !== 16'(exp_stall)) begin
            failures++; $display("FAIL freeze stall_cycles got=%0d want=%0d", stall_cycles, exp_stall);
        end
    endtask

    task automatic test_x0_setclr();
        step_t e;
        tbl.delete();
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,0,0, 5'b10000, 32'h00, 5'd0));
        tbl.push_back(mk(1,0,0,0,0,1,7,0,0,0,0, 5'b10000, 32'h80, 5'd1));
        tbl.push_back(mk(1,0,0,0,0,1,7,0,0,1,7, 5'b10000, 32'h80, 5'd1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,9, 5'b00000, 32'h80, 5'd1));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0,0, 5'b10000, 32'h80, 5'd1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,7, 5'b00000, 32'h00, 5'd0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,7, 5'b00000, 32'h00, 5'd0));
        foreach (tbl[i]) begin
            drive(tbl[i]); #1;
            e = exp_q.pop_front();
            checks++;
            if ({issue, id_stall, if_stall, id_flush, ex_bubble} !== e.outs) begin
                failures++; $display("FAIL x0[%0d] outs got=%b want=%b", i, {issue, id_stall, if_stall, id_flush, ex_bubble}, e.outs);
            end
            if (e.outs[3]) exp_stall++;
            @(posedge clk); #1;
            checks++;
            if (busy_mask !== e.mask || inflight !== e.infl) begin
                failures++; $display("FAIL x0[%0d] state got=%h/%0d want=%h/%0d", i, busy_mask, inflight, e.mask, e.infl);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(mk(1,0,0,0,0,1,3,0,0,0,0, 5'b10000, 32'h08, 5'd1));
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        drive(mk(1,1,3,0,0,0,0,1,0,0,0, 5'b00011, 32'h08, 5'd1));
        void'(exp_q.pop_front());
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle();
        #1;
        checks++; if (busy_mask !== 32'd0 || inflight !== 5'd0) begin failures++; $display("FAIL reset_mid state got=%h/%0d want=0/0", busy_mask, inflight); end
        checks++; if (id_flush !== 1'b0) begin failures++; $display("FAIL reset_mid id_flush got=%b want=0", id_flush); end
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_mid stall_cycles got=%0d want=0", stall_cycles); end
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        test_reset();
        test_raw();
        test_redirect();
        test_capacity();
        test_freeze();
        test_x0_setclr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Scoreboard-based pipeline controller that sequences the fetch/decode stages around the decoder.
- Tracks destination registers of issued-but-not-retired instructions.
- Detects RAW/WAW hazards against the instruction held in decode and caps in-flight writes.
- Drives the decoder's stall and flush inputs, plus the bubble into execute.
- Runs a redirect-flush sequence on taken branches/jumps and freezes the front end while memory is busy.

Parameters:
- FLUSH_CYCLES, 2, cycles id_flush stays asserted after a redirect (including the redirect cycle); legal range 1..15.
- MAX_INFLIGHT, 4, maximum outstanding register writes; legal range 1..31.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1  in  5  source register 1 of the decode instruction.
- id_rs2  in  5  source register 2 of the decode instruction.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  5  destination register.
- id_reg_write  in  1  instruction writes rd.
- ex_redirect  in  1  execute resolved a taken branch/jump this cycle (single-cycle pulse).
- mem_busy  in  1  memory stage cannot accept; freeze front end.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_rd  in  5  register written at writeback.
- issue  out  1  decode instruction moves to execute this cycle.
- if_stall  out  1  hold fetch.
- id_stall  out  1  hold decode register (decoder stall input).
- id_flush  out  1  squash decode register (decoder flush input).
- ex_bubble  out  1  execute must capture a NOP this cycle.
- busy_mask  out  32  scoreboard; bit n = write to xn pending; bit 0 always 0.
- inflight  out  5  count of pending writes.
- stall_cycles  out  CNT_W  saturating count of cycles with id_stall=1.

Behaviour:
- Reset (resetn=0 at posedge): busy_mask=0, inflight=0, state=RUN, flush counter=0, stall_cycles=0. Combinational outputs follow from these values with inputs low.
- Pending-write test (pend(r)):
  - pend(r) = busy_mask[r] && !(wb_valid && wb_rd==r) && r!=0.
  - A same-cycle writeback counts as resolved (the regfile writes through).
- Hazard condition: hazard = id_valid && ((id_uses_rs1 && pend(id_rs1)) || (id_uses_rs2 && pend(id_rs2)) || (id_reg_write && pend(id_rd)) || cap).
- Capacity check: cap = id_reg_write && id_rd!=0 && inflight_eff==MAX_INFLIGHT.
  - inflight_eff = inflight minus 1 if wb_valid && wb_rd!=0 && busy_mask[wb_rd], else inflight.
- FSM states: RUN, FLUSH.
  - RUN + ex_redirect -> FLUSH; counter=FLUSH_CYCLES-1. If FLUSH_CYCLES==1, stay RUN.
  - FLUSH: counter decrements each cycle and is not affected by mem_busy. Counter==0 at posedge -> RUN.
  - FLUSH + ex_redirect: counter reloads to FLUSH_CYCLES-1.
- Outputs (combinational):
  - id_flush = ex_redirect || state==FLUSH.
  - issue = id_valid && state==RUN && !ex_redirect && !mem_busy && !hazard.
  - id_stall = !id_flush && (mem_busy || (id_valid && hazard)).
  - if_stall = id_stall.
  - ex_bubble = !mem_busy && (id_flush || (id_valid && hazard)).
  - Priority: redirect > mem_busy > hazard.
- Scoreboard update per posedge:
  - Clear bit wb_rd if wb_valid.
  - Set bit id_rd if issue && id_reg_write && id_rd!=0.
  - Set wins if both hit the same register.
  - Clear of a non-pending bit is ignored and does not decrement inflight.
  - x0 is never set.
- inflight update per posedge:
  - +1 on set, -1 on an effective clear; both in one cycle = unchanged.
  - Never exceeds MAX_INFLIGHT, never underflows.
- stall_cycles: +1 each cycle id_stall=1; saturates at all-ones.
- Reset mid-operation: all state is cleared regardless of FSM state or pending writes.

Test Plan:
- Reset: hold resetn=0 two cycles with random inputs, then release -> busy_mask=0, inflight=0, issue=0, id_flush=0, stall_cycles=0.
- RAW stall and release:
  - Issue x5 write -> busy_mask=0x20, inflight=1.
  - Next instruction reads rs1=5 -> id_stall=if_stall=ex_bubble=1, issue=0.
  - wb_valid, wb_rd=5 in the following cycle -> issue=1 that same cycle; busy_mask bit5 clears.
- Redirect with FLUSH_CYCLES=2: ex_redirect pulse while id_valid=1 -> id_flush=1 for exactly 2 cycles, issue=0 both cycles, ex_bubble=1; issue resumes cycle 3.
- Capacity (MAX_INFLIGHT=4):
  - Issue writes to x1..x4 -> inflight=4; a 5th write to x6 stalls.
  - wb_rd=1 in the same cycle -> issue=1, inflight stays 4.
- Freeze: mem_busy=1 for 3 cycles with a hazard-free instruction -> id_stall=1, ex_bubble=0, issue=0, stall_cycles +3; mem_busy with ex_redirect -> id_flush=1, id_stall=0.
- x0 and simultaneous set/clear:
  - Issue with id_rd=0 -> busy_mask unchanged.
  - Issue x7 write while wb_rd=7 clears -> bit7 ends 1, inflight unchanged.
